// File: rtl/serial_subtractor.sv
// Bit-serial a-b (LSB first); N+1 enabled edges from accepted start to done, ena=0 stalls everything.
// No backpressure: start is ignored while busy. `define SERIAL_SUB_SIGNED_EN enables the overflow flag.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  sh_q;
  logic          br_q;
  logic [N-1:0]  diff_q;
  logic          borrow_q;

  logic          a_bit;
  logic          b_bit;
  logic          d_bit;
  logic          br_next;
  logic [N-1:0]  sh_next;
  logic          last_bit;

  // Operands stay unshifted and are indexed by the counter, so their MSBs remain available for the overflow term.
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    d_bit    = a_bit ^ b_bit ^ br_q;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    sh_next  = {d_bit, sh_q[N-1:1]};
    last_bit = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sh_q  <= sh_next;
          br_q  <= br_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q   <= sh_next;
            borrow_q <= br_next;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (ena && (state_q == RUN) && last_bit) begin
      ovf_q <= (a_q[N-1] != b_q[N-1]) && (d_bit != a_q[N-1]);
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=8): scoreboard queue of expected results, monitor checks on done rise.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  typedef struct {
    logic [N-1:0] diff;
    logic         brw;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic done_d = 1'b0;

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every rising done must match the head of the scoreboard, including its timing.
  always @(negedge clk) begin
    if (rst_n && done && !done_d) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_done: got done=1 with diff=0x%0h, expected no result", diff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("borrow_out", 32'(borrow_out), 32'(e.brw));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    done_d = done;
  end

  // Called at posedge+1 in IDLE; start is taken on the next edge, done expected N edges later plus stalls.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] ed, input logic eb, input logic eo_signed,
                       input int stall, input bit push);
    exp_t e;
    e.diff = ed;
    e.brw  = eb;
`ifdef SERIAL_SUB_SIGNED_EN
    e.ovf  = eo_signed;
`else
    e.ovf  = 1'b0 & eo_signed;
`endif
    e.cyc  = cyc + 1 + N + stall;
    if (push) exp_q.push_back(e);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    if (busy) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 1'b1);
    chk("busy_in_run", 32'(busy), 32'd1);
    wait_idle();
    issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0, 1'b1);
    wait_idle();
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 1'b1);
    wait_idle();

    // Start during RUN must be ignored without disturbing the result or its timing.
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ena = 1'b1;
    wait_idle();

    issue(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0, 1'b1);
    wait_idle();
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0, 1'b1);
    wait_idle();
    issue(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    // Reset mid-RUN: outputs clear at once and the aborted run never reports.
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow", 32'(borrow_out), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);

    issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0, 1'b1);
    wait_idle();
    issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  clock enable; low freezes all state.
REQ-005 SHALL have port start  input  1  request to begin a subtraction; honoured only in IDLE.
REQ-006 SHALL have port a  input  N  minuend, sampled on the accepted start.
REQ-007 SHALL have port b  input  N  subtrahend, sampled on the accepted start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 SHALL have port diff  output  N  result a-b modulo 2^N, held until the next accepted start.
REQ-011 SHALL have port borrow_out  output  1  unsigned borrow, i.e. a < b, held with diff.
REQ-012 SHALL have port overflow  output  1  signed two's-complement overflow flag, held with diff.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with ena=1 and start=1 on a clock edge: latch a and b, clear internal borrow, clear bit counter, and enter RUN.
REQ-015 SHALL, in RUN with ena=1: compute one bit per cycle, LSB first.
- d = a_i ^ b_i ^ br.
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
- d shifts into the MSB of the result shift register.
- Counter increments.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit N-1, so RUN lasts exactly N enabled cycles.
REQ-017 SHALL update diff, borrow_out and overflow together on the edge entering DONE; done=1 for exactly that one DONE cycle.
REQ-018 SHALL return from DONE to IDLE on the next enabled edge, giving start-to-done latency N+1 enabled edges.
REQ-019 SHALL ignore start while busy=1; operand registers SHALL NOT change.
REQ-020 SHALL, with ena=0, hold state, counter, shift registers and all outputs (done stays high if stalled in DONE).
REQ-021 SHALL accept a start on the same edge that leaves DONE for IDLE is NOT allowed; start is accepted no earlier than the first IDLE cycle.
REQ-022 SHALL produce bit-exact results for all operand pairs, including a=b (diff=0, borrow_out=0) and boundary values 0 and 2^N-1.

Reset
REQ-023 SHALL, while rst_n=0 and regardless of clk: state=IDLE, counter=0, internal borrow=0, operand and result registers=0, busy=0, done=0, diff=0, borrow_out=0, overflow=0.
REQ-024 SHALL abort any operation in progress when reset asserts mid-RUN; no done pulse SHALL follow reset release.

Configuration
REQ-025 SHALL support macro SERIAL_SUB_SIGNED_EN.
- Defined: overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]), computed from the latched operands.
- Undefined: overflow is constant 0 and no overflow logic is synthesised.

Verification
REQ-026 SHALL cover, with N=8: a=0x05, b=0x03, start -> after 9 edges done=1, diff=0x02, borrow_out=0, overflow=0.
REQ-027 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-028 SHALL cover: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1 with SERIAL_SUB_SIGNED_EN defined and 0 without it.
REQ-029 SHALL cover: start pulsed with a=0x00, b=0xFF at cycle 3 of a 0x05-0x03 run -> ignored; done at the original time with diff=0x02.
REQ-030 SHALL cover: ena held low for 4 cycles mid-RUN -> done delayed by exactly 4 cycles; a=0xFF, b=0xFF gives diff=0x00, borrow_out=0.
REQ-031 SHALL cover: rst_n pulsed low at cycle 4 of RUN -> all outputs 0 immediately, busy=0, no done pulse afterwards; the next start completes normally.
